// File: rtl/capp_response_reader.sv
// rtl/capp_response_reader.sv - CAPP responder read-out: snapshots tags, walks them lowest-first, streams selected words
//
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   start, tags        pass request and responder snapshot (sampled in IDLE only)
//   select_lines       one-hot word select into the cell array (SEL state only)
//   read_lines         cell array data for the selected word
//   out_valid/out_ready/out_data/out_index/out_last
//                      captured word stream, one entry per responder
//   busy, done, count  pass status: not-idle, end-of-pass pulse, words delivered
module capp_response_reader #(
  parameter int CELLS  = 100,
  parameter int WIDTH  = 32,
  parameter int IDXW   = 7,
  parameter int SETTLE = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [CELLS-1:0] tags,
  output logic [CELLS-1:0] select_lines,
  input  logic [WIDTH-1:0] read_lines,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [IDXW-1:0]  out_index,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [IDXW:0]    count
);

  typedef enum logic [1:0] {S_IDLE, S_SEL, S_OUT, S_DONE} state_t;

  localparam logic [CELLS-1:0] PEND_ONE    = {{(CELLS-1){1'b0}}, 1'b1};
  localparam logic [IDXW:0]    CNT_ONE     = {{IDXW{1'b0}}, 1'b1};
  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE);

  state_t           state, state_nxt;
  logic [CELLS-1:0] pending;
  logic [3:0]       settle_cnt;
  logic [CELLS-1:0] low_bit;
  logic [IDXW-1:0]  low_idx;
  logic             single;

  // Two's-complement trick isolates the lowest set bit, so select is one-hot by construction.
  assign low_bit = pending & (~pending + PEND_ONE);
  // Clearing the lowest bit leaves zero only when exactly one responder remains.
  assign single  = ((pending & (pending - PEND_ONE)) == '0);

  // Descending scan so the lowest set index is the final assignment.
  always_comb begin
    low_idx = '0;
    for (int i = CELLS - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = IDXW'(i);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    select_lines = '0;
    busy         = (state != S_IDLE);
    done         = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = (tags == '0) ? S_DONE : S_SEL;
      S_SEL: begin
        select_lines = low_bit;
        if (settle_cnt == 4'd1) state_nxt = S_OUT;
      end
      S_OUT:  if (out_ready) state_nxt = out_last ? S_DONE : S_SEL;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pending    <= '0;
      settle_cnt <= '0;
      out_data   <= '0;
      out_index  <= '0;
      out_last   <= 1'b0;
      out_valid  <= 1'b0;
      count      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pending    <= tags;
            count      <= '0;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        S_SEL: begin
          settle_cnt <= settle_cnt - 4'd1;
          // Capture on the edge where the settle counter reaches zero.
          if (settle_cnt == 4'd1) begin
            out_data  <= read_lines;
            out_index <= low_idx;
            out_last  <= single;
            out_valid <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            pending    <= pending & (pending - PEND_ONE);
            count      <= count + CNT_ONE;
            out_valid  <= 1'b0;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
